uart_io_ctrl: RTL and testbench
===============================

# uart_io_ctrl

Sequences UART traffic into and out of the pipelined CPU. Received bytes become operand1/operand2 register writes through the register-file write port, which it shares with the CPU's MEM/WB writeback (writeback always wins). It raises an interrupt once both operands are loaded, and drives the UART transmitter from a one-byte CPU request through a small handshake FSM. It sits between the UART rx/tx cores, the ID-stage register file and the interrupt input of IF.

## Interface
- OP1_REG, 5'd4: register index written by even (first) UART bytes.
- OP2_REG, 5'd5: register index written by odd (second) UART bytes.
- TX_TIMEOUT, 4: cycles allowed for tx_busy to rise after tx_start.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: new byte on rx_data.
- rx_data  in  8  received byte.
- wb_en  in  1  CPU writeback request this cycle.
- wb_addr  in  5  CPU writeback register.
- wb_data  in  32  CPU writeback data.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- uart_flag  out  1  target of next accepted rx byte: 0=OP1_REG, 1=OP2_REG.
- irq  out  1  operand pair loaded; level until acknowledged.
- irq_ack  in  1  one-cycle acknowledge from the CPU.
- overrun  out  1  sticky: an rx byte was dropped.
- tx_req  in  1  CPU requests transmission of tx_byte.
- tx_byte  in  8  byte to send.
- tx_ready  out  1  high only in TX IDLE; tx_req is accepted only then.
- tx_start  out  1  one-cycle start pulse to UART tx core.
- tx_data  out  8  latched byte, stable from tx_start until return to IDLE.
- tx_busy  in  1  UART tx core busy.

## Operation
- Reset: FIFO empty, uart_flag=0, irq=0, overrun=0, TX state IDLE, tx_start=0, tx_data=8'h00, tx_ready=1.
- RX FIFO: 2 entries of {flag, byte}. On rx_valid and not full (or full with a pop in the same cycle): push {uart_flag, rx_data}, toggle uart_flag. On rx_valid while full and no pop: byte dropped, overrun set, uart_flag unchanged.
- Write port (combinational mux): wb_en=1 -> rf_we=1, rf_waddr=wb_addr, rf_wdata=wb_data, no pop. wb_en=0 and FIFO non-empty -> rf_we=1, rf_waddr = head.flag ? OP2_REG : OP1_REG, rf_wdata = {24'b0, head.byte}, head popped at edge. Otherwise rf_we=0, rf_waddr/rf_wdata = wb_addr/wb_data.
- CPU writeback never stalls; UART writes wait indefinitely behind wb_en.
- IRQ: a pop of an entry with flag=1 sets irq at that edge. irq_ack=1 clears irq; simultaneous set and ack -> irq stays 1. Overlapping pairs do not queue a second irq.
- TX FSM: IDLE --tx_req--> START (latch tx_byte into tx_data). START: tx_start=1 for exactly one cycle -> WAIT_BUSY. WAIT_BUSY: tx_busy=1 -> WAIT_DONE; no tx_busy after TX_TIMEOUT cycles -> IDLE. WAIT_DONE: tx_busy=0 -> IDLE. tx_req outside IDLE is ignored (not queued).
- rst mid-transfer: FSM to IDLE, FIFO flushed, irq and overrun cleared, uart_flag=0, in the same edge.

## Timing
- rx_valid at edge N -> earliest rf_we for that byte in cycle N+1 (if wb_en=0).
- Pop of flag=1 entry in cycle N -> irq=1 from N+1.
- tx_req accepted in cycle N -> tx_start=1 in cycle N+1, tx_ready=0 from N+1 until the cycle after IDLE is re-entered.
- Outputs rf_* are combinational from wb_* and FIFO head; all others are registered.

## Test plan
- rx bytes 8'h12 then 8'h34, wb_en=0 -> writes (5'd4, 32'h12) then (5'd5, 32'h34); irq=1 the cycle after the second write; irq_ack clears it next edge.
- wb_en held 1 for 5 cycles while 8'h12, 8'h34 arrive -> only CPU writes appear; both UART writes follow in the 2 cycles after wb_en drops, in order.
- Third rx byte 8'h56 while FIFO full and wb_en=1 -> byte dropped, overrun=1, uart_flag unchanged; at full, rx_valid with a simultaneous pop -> accepted, no overrun.
- tx_req with tx_byte=8'hA5, tx_busy rises 2 cycles after tx_start, falls 10 cycles later -> one tx_start pulse, tx_data=8'hA5 throughout, tx_ready returns 1 after tx_busy falls; a tx_req during transfer is ignored.
- tx_busy never rises -> FSM returns to IDLE after 4 cycles in WAIT_BUSY, tx_ready=1.
- rst asserted with one FIFO entry, irq=1, TX in WAIT_DONE -> next cycle all outputs at reset values, no pending UART write.

Source files
------------

// File: rtl/uart_io_ctrl_if.sv
// Bus bundle between uart_io_ctrl and its surroundings: UART rx/tx cores,
// CPU writeback, register-file write port and the interrupt line.
interface uart_io_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        uart_flag;
  logic        irq;
  logic        irq_ack;
  logic        overrun;
  logic        tx_req;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  modport master (
    output rx_valid, rx_data, wb_en, wb_addr, wb_data, irq_ack,
           tx_req, tx_byte, tx_busy,
    input  rf_we, rf_waddr, rf_wdata, uart_flag, irq, overrun,
           tx_ready, tx_start, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, wb_en, wb_addr, wb_data, irq_ack,
           tx_req, tx_byte, tx_busy,
    output rf_we, rf_waddr, rf_wdata, uart_flag, irq, overrun,
           tx_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_io_ctrl.sv
// UART <-> CPU sequencer: rx bytes become operand register writes sharing the
// writeback port (writeback has priority), plus a one-byte tx handshake FSM.
module uart_io_ctrl (
  input  logic          clk,
  input  logic          rst,
  uart_io_ctrl_if.slave bus
);
  localparam logic [4:0]  OP1_REG    = 5'd4;
  localparam logic [4:0]  OP2_REG    = 5'd5;
  localparam int unsigned TX_TIMEOUT = 4;
  localparam int unsigned TMR_W      = 3;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_e;

  rx_entry_t  fifo_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q, count_d;
  logic       uart_flag_q;
  logic       irq_q, irq_d;
  logic       overrun_q;

  rx_entry_t  head;
  logic       fifo_empty, fifo_full;
  logic       pop, push, drop;

  tx_state_e        state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             tx_start_q, tx_ready_q;
  logic [7:0]       tx_data_q;

  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (count_q == 2'd0);
  assign fifo_full  = (count_q == 2'd2);
  assign pop        = !bus.wb_en && !fifo_empty;
  assign push       = bus.rx_valid && (!fifo_full || pop);
  assign drop       = bus.rx_valid && fifo_full && !pop;
  assign count_d    = count_q + 2'(push) - 2'(pop);
  assign irq_d      = (pop && head.flag) || (irq_q && !bus.irq_ack);

  // Shared write port: CPU writeback first, then the FIFO head.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = bus.wb_addr;
    bus.rf_wdata = bus.wb_data;
    if (bus.wb_en) begin
      bus.rf_we = 1'b1;
    end else if (!fifo_empty) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = head.flag ? OP2_REG : OP1_REG;
      bus.rf_wdata = {24'h0, head.data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      uart_flag_q <= 1'b0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{flag: uart_flag_q, data: bus.rx_data};
        wr_ptr_q         <= ~wr_ptr_q;
        uart_flag_q      <= ~uart_flag_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  // Transmit handshake; a missing tx_busy response times out back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      tmr_q      <= '0;
      tx_start_q <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (bus.tx_req) begin
            state_q    <= TX_START;
            tx_data_q  <= bus.tx_byte;
            tx_start_q <= 1'b1;
            tx_ready_q <= 1'b0;
          end
        end
        TX_START: begin
          state_q    <= TX_WAIT_BUSY;
          tx_start_q <= 1'b0;
          tmr_q      <= '0;
        end
        TX_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_q <= TX_WAIT_DONE;
          end else if (tmr_q == TMR_W'(TX_TIMEOUT - 1)) begin
            state_q    <= TX_IDLE;
            tx_ready_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        TX_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state_q    <= TX_IDLE;
            tx_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= TX_IDLE;
          tx_start_q <= 1'b0;
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.uart_flag = uart_flag_q;
  assign bus.irq       = irq_q;
  assign bus.overrun   = overrun_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.tx_data   = tx_data_q;
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl: per-cycle scoreboard of the shared write
// port fed by a small FIFO/irq model, plus directed tx handshake checks.
module tb_uart_io_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_io_ctrl_if bus ();
  uart_io_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_exp_t;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
  } ent_t;

  rf_exp_t exp_q[$];
  ent_t    m_fifo[$];
  logic    m_flag, m_irq, m_ovr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One scoreboard entry is consumed per cycle, mid-cycle.
  always @(negedge clk) begin
    rf_exp_t e, o;
    o = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_port", 64'(o), 64'(e));
    end else if (bus.rf_we === 1'b1) begin
      chk("rf_unexpected", 64'(bus.rf_we), 64'(1'b0));
    end
  end

  // Predict this cycle's write port, advance the model, run one clock.
  task automatic tick();
    rf_exp_t e;
    ent_t    h;
    logic    pop;
    h   = '0;
    pop = !bus.wb_en && (m_fifo.size() > 0);
    if (bus.wb_en) begin
      e = {1'b1, bus.wb_addr, bus.wb_data};
    end else if (pop) begin
      h = m_fifo[0];
      e = {1'b1, (h.flag ? 5'd5 : 5'd4), {24'h0, h.data}};
    end else begin
      e = {1'b0, bus.wb_addr, bus.wb_data};
    end
    exp_q.push_back(e);
    if (rst) begin
      m_fifo.delete();
      m_flag = 1'b0;
      m_irq  = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (bus.rx_valid) begin
        if (m_fifo.size() < 2) begin
          m_fifo.push_back({m_flag, bus.rx_data});
          m_flag = !m_flag;
        end else begin
          m_ovr = 1'b1;
        end
      end
      m_irq = (pop && h.flag) || (m_irq && !bus.irq_ack);
    end
    @(posedge clk);
    #1;
    chk("irq", 64'(bus.irq), 64'(m_irq));
    chk("overrun", 64'(bus.overrun), 64'(m_ovr));
    chk("uart_flag", 64'(bus.uart_flag), 64'(m_flag));
  endtask

  task automatic tx_chk(input string tag, input logic st, input logic rdy, input logic [7:0] d);
    chk({tag, "_start"}, 64'(bus.tx_start), 64'(st));
    chk({tag, "_ready"}, 64'(bus.tx_ready), 64'(rdy));
    chk({tag, "_data"}, 64'(bus.tx_data), 64'(d));
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'h0;
    bus.irq_ack = 1'b0; bus.tx_req = 1'b0; bus.tx_byte = 8'h00; bus.tx_busy = 1'b0;
    m_flag = 1'b0; m_irq = 1'b0; m_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_irq", 64'(bus.irq), 64'(1'b0));
    chk("rst_overrun", 64'(bus.overrun), 64'(1'b0));
    chk("rst_flag", 64'(bus.uart_flag), 64'(1'b0));
    chk("rst_rf_we", 64'(bus.rf_we), 64'(1'b0));
    tx_chk("rst", 1'b0, 1'b1, 8'h00);

    // Two bytes with a free write port, then acknowledge the irq.
    bus.wb_addr = 5'd17; bus.wb_data = 32'hDEAD_0001;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h12; tick();
    bus.rx_data = 8'h34; tick();
    bus.rx_valid = 1'b0; tick();
    tick();
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; tick();

    // Writeback holds the port for 5 cycles while two bytes arrive.
    for (int i = 0; i < 5; i++) begin
      bus.wb_en    = 1'b1;
      bus.wb_addr  = 5'(10 + i);
      bus.wb_data  = 32'hC000_0000 + 32'(i);
      bus.rx_valid = (i == 0) || (i == 2);
      bus.rx_data  = (i == 0) ? 8'h12 : 8'h34;
      tick();
    end
    bus.wb_en = 1'b0; bus.rx_valid = 1'b0; bus.wb_addr = 5'd3; bus.wb_data = 32'h1234_5678;
    repeat (3) tick();
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0;

    // Fill, accept while full with a pop, then drop a byte into a full FIFO.
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hAAAA_5555;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h12; tick();
    bus.rx_data = 8'h34; tick();
    bus.wb_en = 1'b0; bus.rx_data = 8'h78; tick();
    bus.wb_en = 1'b1; bus.rx_data = 8'h56; tick();
    bus.wb_en = 1'b0; bus.rx_valid = 1'b0;
    repeat (3) tick();
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; tick();

    // Normal transmit with a request arriving mid-transfer.
    bus.tx_req = 1'b1; bus.tx_byte = 8'hA5; tick();
    tx_chk("tx_accept", 1'b1, 1'b0, 8'hA5);
    bus.tx_req = 1'b0; tick();
    tx_chk("tx_wait0", 1'b0, 1'b0, 8'hA5);
    bus.tx_req = 1'b1; bus.tx_byte = 8'hFF; tick();
    tx_chk("tx_wait1", 1'b0, 1'b0, 8'hA5);
    bus.tx_req = 1'b0; bus.tx_busy = 1'b1; tick();
    for (int i = 0; i < 9; i++) begin
      tick();
      tx_chk("tx_busy", 1'b0, 1'b0, 8'hA5);
    end
    bus.tx_busy = 1'b0; tick();
    tx_chk("tx_done", 1'b0, 1'b1, 8'hA5);
    tick();
    tx_chk("tx_idle", 1'b0, 1'b1, 8'hA5);

    // tx_busy never answers: timeout back to idle.
    bus.tx_req = 1'b1; bus.tx_byte = 8'h5A; tick();
    bus.tx_req = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      tx_chk("tx_timeout", 1'b0, (k == 3), 8'h5A);
    end

    // Reset with a pending byte, irq high, sticky overrun and tx in WAIT_DONE.
    bus.rx_valid = 1'b1; bus.rx_data = 8'h9A; tick();
    bus.rx_data = 8'hBC; tick();
    bus.rx_valid = 1'b0; tick();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd20; bus.wb_data = 32'h0BAD_F00D;
    bus.rx_valid = 1'b1; bus.rx_data = 8'hDE; tick();
    bus.rx_valid = 1'b0; bus.tx_req = 1'b1; bus.tx_byte = 8'h3C; tick();
    bus.tx_req = 1'b0; tick();
    bus.tx_busy = 1'b1; tick();
    tx_chk("pre_rst", 1'b0, 1'b0, 8'h3C);
    rst = 1'b1; tick();
    tx_chk("post_rst", 1'b0, 1'b1, 8'h00);
    rst = 1'b0; bus.wb_en = 1'b0; bus.tx_busy = 1'b0; tick();
    tick();

    chk("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
